// File: rtl/seg7_scan_driver_pkg.sv
// seg7_scan_driver_pkg: segment patterns and digit count shared by the display driver and counter chain
package seg7_scan_driver_pkg;
   localparam int NUM_DIGITS = 4;
   // Active-low {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_0    = 7'h40;
   localparam logic [6:0] SEG_1    = 7'h79;
   localparam logic [6:0] SEG_2    = 7'h24;
   localparam logic [6:0] SEG_3    = 7'h30;
   localparam logic [6:0] SEG_4    = 7'h19;
   localparam logic [6:0] SEG_5    = 7'h12;
   localparam logic [6:0] SEG_6    = 7'h02;
   localparam logic [6:0] SEG_7    = 7'h78;
   localparam logic [6:0] SEG_8    = 7'h00;
   localparam logic [6:0] SEG_9    = 7'h10;
   localparam logic [6:0] SEG_DASH = 7'h3F;
   localparam logic [6:0] SEG_OFF  = 7'h7F;
   localparam logic [6:0] SEG_LUT [16] = '{SEG_0, SEG_1, SEG_2, SEG_3, SEG_4, SEG_5, SEG_6, SEG_7,
                                           SEG_8, SEG_9, SEG_DASH, SEG_DASH, SEG_DASH, SEG_DASH,
                                           SEG_DASH, SEG_DASH};
endpackage

// File: rtl/bcd_to_seg7.sv
// bcd_to_seg7: BCD digit to active-low 7-segment pattern, dash for non-decimal codes
module bcd_to_seg7
   import seg7_scan_driver_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);
   assign seg = SEG_LUT[bcd];
endmodule

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: multiplexed 4-digit common-anode display with zero blanking, decimal points and blink
module seg7_scan_driver
   import seg7_scan_driver_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 125
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [15:0] digits,
   input  logic [3:0]  dp_mask,
   input  logic        blank_lz,
   input  logic        blink_en,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);
   localparam int RW = $clog2(REFRESH_DIV);
   localparam int BW = BLINK_DIV > 1 ? $clog2(BLINK_DIV) : 1;
   logic [RW-1:0] rcnt, rcnt_nxt;
   logic [BW-1:0] fcnt, fcnt_nxt;
   logic [1:0]    idx, idx_nxt;
   logic          started, phase, phase_nxt, tick, wrap, load, blk;
   logic [15:0]   sh_dig, dig_nxt;
   logic [3:0]    sh_dp, dp_nxt, lz, cur;
   logic [6:0]    seg_dec;
   bcd_to_seg7 u_dec (.bcd(cur), .seg(seg_dec));
   // Decode from next-state values so the lit digit always matches the index being registered
   always_comb begin
      tick      = started && rcnt == RW'(REFRESH_DIV - 1);
      wrap      = tick && idx == 2'd3;
      load      = wrap || !started;
      rcnt_nxt  = !started ? rcnt : tick ? '0 : rcnt + 1'b1;
      idx_nxt   = tick ? idx + 2'd1 : idx;
      dig_nxt   = load ? digits : sh_dig;
      dp_nxt    = load ? dp_mask : sh_dp;
      cur       = dig_nxt[{idx_nxt, 2'b00} +: 4];
      lz[3]     = dig_nxt[15:12] == 4'd0;
      lz[2]     = lz[3] && dig_nxt[11:8] == 4'd0;
      lz[1]     = lz[2] && dig_nxt[7:4] == 4'd0;
      lz[0]     = 1'b0;
      blk       = blank_lz && lz[idx_nxt];
      fcnt_nxt  = !blink_en ? '0 : !wrap ? fcnt : fcnt == BW'(BLINK_DIV - 1) ? '0 : fcnt + 1'b1;
      phase_nxt = blink_en && (wrap && fcnt == BW'(BLINK_DIV - 1) ? !phase : phase);
   end
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         started <= 1'b0;
         rcnt    <= '0;
         idx     <= 2'd0;
         fcnt    <= '0;
         phase   <= 1'b0;
         sh_dig  <= 16'h0000;
         sh_dp   <= 4'h0;
         an      <= 4'b1111;
         seg     <= SEG_OFF;
         dp      <= 1'b1;
      end else begin
         started <= 1'b1;
         rcnt    <= rcnt_nxt;
         idx     <= idx_nxt;
         fcnt    <= fcnt_nxt;
         phase   <= phase_nxt;
         sh_dig  <= dig_nxt;
         sh_dp   <= dp_nxt;
         an      <= phase_nxt ? 4'b1111 : ~(4'b0001 << idx_nxt);
         seg     <= blk ? SEG_OFF : seg_dec;
         dp      <= blk || !dp_nxt[idx_nxt];
      end
   end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed checks of scan order, blanking, tear-free capture, dash/dp, blink and async reset
module tb_seg7_scan_driver;
   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic [15:0] digits = 16'h0000;
   logic [3:0]  dp_mask = 4'h0;
   logic        blank_lz = 1'b0;
   logic        blink_en = 1'b0;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   int vecs = 0;
   int errs = 0;
   always #5 clk = ~clk;
   seg7_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
      .clk(clk), .reset(reset), .digits(digits), .dp_mask(dp_mask), .blank_lz(blank_lz),
      .blink_en(blink_en), .an(an), .seg(seg), .dp(dp)
   );
   function automatic logic [6:0] pat(input logic [3:0] d);
      case (d)
         4'd0: return 7'h40;
         4'd1: return 7'h79;
         4'd2: return 7'h24;
         4'd3: return 7'h30;
         4'd4: return 7'h19;
         4'd5: return 7'h12;
         4'd6: return 7'h02;
         4'd7: return 7'h78;
         4'd8: return 7'h00;
         4'd9: return 7'h10;
         default: return 7'h3F;
      endcase
   endfunction
   function automatic logic [3:0] anode(input int s);
      return ~(4'b0001 << s);
   endfunction
   // Every task begins with the next negedge showing the first cycle of slot 0
   task automatic test_reset;
      repeat (3) @(negedge clk);
      vecs++;
      if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
         errs++;
         $display("FAIL reset: an=%b seg=%h dp=%b, want an=1111 seg=7f dp=1", an, seg, dp);
      end
      digits = 16'h1234;
      reset = 1'b1;
   endtask
   task automatic test_scan;
      logic [15:0] w = 16'h1234;
      for (int f = 0; f < 2; f++)
         for (int s = 0; s < 4; s++)
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               vecs++;
               if (an !== anode(s) || seg !== pat(w[4*s +: 4]) || dp !== 1'b1) begin
                  errs++;
                  $display("FAIL scan f%0d s%0d c%0d: an=%b seg=%h dp=%b, want an=%b seg=%h dp=1",
                           f, s, c, an, seg, dp, anode(s), pat(w[4*s +: 4]));
               end
            end
   endtask
   task automatic test_blank;
      logic [15:0] w [3] = '{16'h0070, 16'h0070, 16'h0000};
      logic        b [3] = '{1'b1, 1'b0, 1'b1};
      logic [6:0]  e [3][4] = '{'{7'h40, 7'h78, 7'h7F, 7'h7F},
                                 '{7'h40, 7'h78, 7'h40, 7'h40},
                                 '{7'h40, 7'h7F, 7'h7F, 7'h7F}};
      for (int f = 0; f < 3; f++) begin
         digits = w[f];
         blank_lz = b[f];
         for (int s = 0; s < 4; s++)
            for (int c = 0; c < 4; c++) begin
               @(negedge clk);
               vecs++;
               if (an !== anode(s) || seg !== e[f][s] || dp !== 1'b1) begin
                  errs++;
                  $display("FAIL blank f%0d s%0d: an=%b seg=%h dp=%b, want an=%b seg=%h dp=1",
                           f, s, an, seg, dp, anode(s), e[f][s]);
               end
            end
      end
      blank_lz = 1'b0;
   endtask
   task automatic test_no_tear;
      logic [15:0] w;
      digits = 16'h1234;
      for (int f = 0; f < 3; f++)
         for (int s = 0; s < 4; s++)
            for (int c = 0; c < 4; c++) begin
               w = f == 2 ? 16'h5678 : 16'h1234;
               @(negedge clk);
               vecs++;
               if (an !== anode(s) || seg !== pat(w[4*s +: 4])) begin
                  errs++;
                  $display("FAIL no_tear f%0d s%0d c%0d: an=%b seg=%h, want an=%b seg=%h",
                           f, s, c, an, seg, anode(s), pat(w[4*s +: 4]));
               end
               if (f == 1 && s == 1 && c == 1) digits = 16'h5678;
            end
   endtask
   task automatic test_dash_dp;
      logic [15:0] w = 16'h12C4;
      digits = w;
      dp_mask = 4'b0010;
      for (int s = 0; s < 4; s++)
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vecs++;
            if (an !== anode(s) || seg !== pat(w[4*s +: 4]) || dp !== (s != 1)) begin
               errs++;
               $display("FAIL dash_dp s%0d: an=%b seg=%h dp=%b, want an=%b seg=%h dp=%b",
                        s, an, seg, dp, anode(s), pat(w[4*s +: 4]), s != 1);
            end
         end
      dp_mask = 4'b0000;
   endtask
   task automatic test_blink;
      logic [3:0] ea;
      digits = 16'h1234;
      @(negedge clk);
      blink_en = 1'b1;
      for (int f = 1; f <= 6; f++)
         for (int s = 0; s < 4; s++)
            for (int c = 0; c < 4; c++) begin
               if (f == 1 && s == 0 && c == 0) continue;
               ea = (f == 3 || f == 4) ? 4'b1111 : anode(s);
               @(negedge clk);
               vecs++;
               if (an !== ea) begin
                  errs++;
                  $display("FAIL blink f%0d s%0d c%0d: an=%b, want %b", f, s, c, an, ea);
               end
            end
      for (int s = 0; s < 4; s++)
         for (int c = 0; c < 4; c++) begin
            ea = (s == 0 || (s == 1 && c < 2)) ? 4'b1111 : anode(s);
            @(negedge clk);
            if (s != 1 || c < 2) begin
               vecs++;
               if (an !== ea) begin
                  errs++;
                  $display("FAIL blink_drop s%0d c%0d: an=%b, want %b", s, c, an, ea);
               end
            end
            if (s == 1 && c == 1) blink_en = 1'b0;
         end
   endtask
   task automatic test_reset_mid;
      logic [15:0] w = 16'h1234;
      digits = w;
      repeat (9) @(negedge clk);
      vecs++;
      if (an !== 4'b1011) begin
         errs++;
         $display("FAIL reset_mid_pre: an=%b, want 1011", an);
      end
      #2 reset = 1'b0;
      #1;
      vecs++;
      if (an !== 4'b1111 || seg !== 7'h7F || dp !== 1'b1) begin
         errs++;
         $display("FAIL reset_mid_async: an=%b seg=%h dp=%b, want an=1111 seg=7f dp=1", an, seg, dp);
      end
      repeat (2) @(negedge clk);
      reset = 1'b1;
      for (int s = 0; s < 2; s++)
         for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            vecs++;
            if (an !== anode(s) || seg !== pat(w[4*s +: 4])) begin
               errs++;
               $display("FAIL reset_mid_restart s%0d c%0d: an=%b seg=%h, want an=%b seg=%h",
                        s, c, an, seg, anode(s), pat(w[4*s +: 4]));
            end
         end
   endtask
   initial begin
      test_reset;
      test_scan;
      test_blank;
      test_no_tear;
      test_dash_dp;
      test_blink;
      test_reset_mid;
      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end
endmodule
